// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and helpers for the ordered reset-release sequencer.
//   state_t      - sequencer FSM states
//   stage_width  - width of the stage index, at least 1 bit
//   hold_slice   - picks one channel's hold count out of the packed hold vector
package reset_seq_pkg;

    // Large enough for 16 channels of up to 32-bit counters.
    localparam int HOLD_VEC_W = 16 * 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT_READY,
        S_DONE,
        S_FAULT
    } state_t;

    function automatic int stage_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A width of 32 makes the shift overflow to 0, so the mask becomes all ones.
    function automatic logic [31:0] hold_slice(
        input logic [HOLD_VEC_W-1:0] holds,
        input int                    width,
        input int                    idx
    );
        logic [HOLD_VEC_W-1:0] v;
        v = holds >> (idx * width);
        return 32'(v) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a vector of independent asynchronous bits.
//   i_Clock    - destination clock
//   i_Reset_N  - asynchronous active-low reset, clears both stages to 0
//   i_D        - asynchronous input bits
//   o_Q        - synchronized bits, two edges of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset_N,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_CHANNELS downstream resets in order, each after
// its own hold time, optionally waiting for a per-channel ready before moving on.
//   i_Clock    - system clock
//   i_Reset_N  - asynchronous active-low reset
//   i_Enable   - synchronous sequence enable; low aborts back to idle
//   i_Ready    - per-channel ready, asynchronous (synchronized internally)
//   o_Release  - 1 = channel k out of reset
//   o_Stage    - index of the active stage
//   o_Done     - all channels released and all masked readies seen
//   o_Fault    - ready-wait timeout occurred
// Optional feature: define RESET_SEQ_TIMEOUT_EN to bound the ready wait with
// TIMEOUT_CYCLES and enter a fault state on expiry.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                                    NUM_CHANNELS   = 4,
    parameter int                                    COUNTER_WIDTH  = 15,
    parameter logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] HOLD_CYCLES    = {NUM_CHANNELS{COUNTER_WIDTH'(20000)}},
    parameter logic [NUM_CHANNELS-1:0]               READY_MASK     = '1,
    parameter logic [COUNTER_WIDTH-1:0]              TIMEOUT_CYCLES = COUNTER_WIDTH'(30000)
) (
    input  logic                                    i_Clock,
    input  logic                                    i_Reset_N,
    input  logic                                    i_Enable,
    input  logic [NUM_CHANNELS-1:0]                 i_Ready,
    output logic [NUM_CHANNELS-1:0]                 o_Release,
    output logic [stage_width(NUM_CHANNELS)-1:0]    o_Stage,
    output logic                                    o_Done,
    output logic                                    o_Fault
);

    localparam int                     STAGE_WIDTH = stage_width(NUM_CHANNELS);
    localparam logic [STAGE_WIDTH-1:0] LAST_STAGE  = STAGE_WIDTH'(NUM_CHANNELS - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_count_nxt;
    logic [STAGE_WIDTH-1:0]   r_stage;
    logic [STAGE_WIDTH-1:0]   w_stage_nxt;
    logic [NUM_CHANNELS-1:0]  r_release;
    logic [NUM_CHANNELS-1:0]  w_release_nxt;
    logic [NUM_CHANNELS-1:0]  w_ready_sync;
    logic [NUM_CHANNELS-1:0]  w_stage_bit;
    logic [COUNTER_WIDTH-1:0] w_hold;
    logic                     w_ready;
    logic                     w_wait_ready;
    logic                     w_last;

    sync_2ff #(
        .WIDTH (NUM_CHANNELS)
    ) u_ready_sync (
        .i_Clock   (i_Clock),
        .i_Reset_N (i_Reset_N),
        .i_D       (i_Ready),
        .o_Q       (w_ready_sync)
    );

    // One-hot of the active stage; masking instead of indexing keeps
    // non-power-of-two channel counts free of out-of-range selects.
    assign w_stage_bit  = NUM_CHANNELS'(1) << r_stage;
    assign w_ready      = |(w_ready_sync & w_stage_bit);
    assign w_wait_ready = |(READY_MASK & w_stage_bit);
    assign w_last       = r_stage == LAST_STAGE;
    assign w_hold       = COUNTER_WIDTH'(hold_slice(HOLD_VEC_W'(HOLD_CYCLES), COUNTER_WIDTH, int'(r_stage)));

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_stage   <= '0;
            r_release <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_stage   <= w_stage_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_stage_nxt   = r_stage;
        w_release_nxt = r_release;
        if (!i_Enable) begin
            w_state_nxt   = S_IDLE;
            w_count_nxt   = '0;
            w_stage_nxt   = '0;
            w_release_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt   = S_HOLD;
                    w_count_nxt   = '0;
                    w_stage_nxt   = '0;
                    w_release_nxt = '0;
                end
                S_HOLD: begin
                    if (r_count >= w_hold) begin
                        w_release_nxt = r_release | w_stage_bit;
                        w_count_nxt   = '0;
                        if (w_wait_ready)
                            w_state_nxt = S_WAIT_READY;
                        else if (w_last)
                            w_state_nxt = S_DONE;
                        else
                            w_stage_nxt = r_stage + STAGE_WIDTH'(1);
                    end else begin
                        w_count_nxt = r_count + COUNTER_WIDTH'(1);
                    end
                end
                S_WAIT_READY: begin
                    if (w_ready) begin
                        w_count_nxt = '0;
                        w_state_nxt = w_last ? S_DONE : S_HOLD;
                        w_stage_nxt = w_last ? r_stage : r_stage + STAGE_WIDTH'(1);
                    end else if (TIMEOUT_EN && r_count >= TIMEOUT_CYCLES) begin
                        // Stage stays frozen so software can see which channel failed.
                        w_state_nxt   = S_FAULT;
                        w_count_nxt   = '0;
                        w_release_nxt = '0;
                    end else if (TIMEOUT_EN) begin
                        w_count_nxt = r_count + COUNTER_WIDTH'(1);
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                S_FAULT: w_state_nxt = S_FAULT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_Release = r_release;
    assign o_Stage   = r_stage;
    assign o_Done    = r_state == S_DONE;
`ifdef RESET_SEQ_TIMEOUT_EN
    assign o_Fault   = r_state == S_FAULT;
`else
    assign o_Fault   = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer with 3 channels,
// holds {0,2,4}, ready mask 3'b001 and timeout 8. Edge numbers in the notes
// below count from the edge that leaves IDLE (E0).
module tb_reset_sequencer;

    logic       i_Clock = 1'b0;
    logic       i_Reset_N;
    logic       i_Enable;
    logic [2:0] i_Ready;
    logic [2:0] o_Release;
    logic [1:0] o_Stage;
    logic       o_Done;
    logic       o_Fault;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .NUM_CHANNELS   (3),
        .COUNTER_WIDTH  (15),
        .HOLD_CYCLES    ({15'd0, 15'd2, 15'd4}),
        .READY_MASK     (3'b001),
        .TIMEOUT_CYCLES (15'd8)
    ) dut (
        .i_Clock   (i_Clock),
        .i_Reset_N (i_Reset_N),
        .i_Enable  (i_Enable),
        .i_Ready   (i_Ready),
        .o_Release (o_Release),
        .o_Stage   (o_Stage),
        .o_Done    (o_Done),
        .o_Fault   (o_Fault)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] rel, input logic [1:0] stg,
                              input logic dn, input logic flt);
        chk({tag, ".release"}, 32'(o_Release), 32'(rel));
        chk({tag, ".stage"},   32'(o_Stage),   32'(stg));
        chk({tag, ".done"},    32'(o_Done),    32'(dn));
        chk({tag, ".fault"},   32'(o_Fault),   32'(flt));
    endtask

    initial begin
        i_Reset_N = 1'b0;
        i_Enable  = 1'b0;
        i_Ready   = 3'b000;
        #12;
        expect_out("reset", 3'b000, 2'd0, 1'b0, 1'b0);
        #10;
        i_Reset_N = 1'b1;

        // Ready already high: stage 0 waits, stage 1 and 2 are unmasked.
        i_Ready = 3'b001;
        tick(3);
        expect_out("idle", 3'b000, 2'd0, 1'b0, 1'b0);
        i_Enable = 1'b1;
        tick(1);
        expect_out("t1_e0", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(4);
        expect_out("t1_e4", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_e5", 3'b001, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_e6", 3'b001, 2'd1, 1'b0, 1'b0);
        tick(2);
        expect_out("t1_e8", 3'b001, 2'd1, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_e9", 3'b011, 2'd2, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_e10", 3'b111, 2'd2, 1'b1, 1'b0);
        tick(5);
        expect_out("t1_hold_done", 3'b111, 2'd2, 1'b1, 1'b0);

        // Abort from DONE, then abort mid-sequence at E7 and re-enable at E10.
        i_Enable = 1'b0;
        tick(1);
        expect_out("abort_done", 3'b000, 2'd0, 1'b0, 1'b0);
        i_Enable = 1'b1;
        tick(1);
        tick(7);
        expect_out("t3_e7", 3'b001, 2'd1, 1'b0, 1'b0);
        i_Enable = 1'b0;
        tick(1);
        expect_out("t3_e8", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("t3_e9", 3'b000, 2'd0, 1'b0, 1'b0);
        i_Enable = 1'b1;
        tick(1);
        tick(4);
        expect_out("t3_e14", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("t3_e15", 3'b001, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset in the stage-1 hold, away from any clock edge.
        tick(2);
        expect_out("rst_pre", 3'b001, 2'd1, 1'b0, 1'b0);
        #2;
        i_Reset_N = 1'b0;
        #1;
        expect_out("rst_async", 3'b000, 2'd0, 1'b0, 1'b0);
        #2;
        i_Reset_N = 1'b1;
        tick(1);
        expect_out("rst_e0", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(4);
        expect_out("rst_e4", 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("rst_e5", 3'b001, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("rst_e6", 3'b001, 2'd1, 1'b0, 1'b0);

        // Restart with ready low so stage 0 has to wait.
        i_Enable = 1'b0;
        i_Ready  = 3'b000;
        tick(3);
        expect_out("t2_idle", 3'b000, 2'd0, 1'b0, 1'b0);
        i_Enable = 1'b1;
        tick(1);
        tick(5);
        expect_out("t2_e5", 3'b001, 2'd0, 1'b0, 1'b0);
`ifdef RESET_SEQ_TIMEOUT_EN
        tick(8);
        expect_out("to_e13", 3'b001, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("to_e14", 3'b000, 2'd0, 1'b0, 1'b1);
        tick(3);
        expect_out("to_held", 3'b000, 2'd0, 1'b0, 1'b1);
        i_Enable = 1'b0;
        tick(1);
        expect_out("to_clear", 3'b000, 2'd0, 1'b0, 1'b0);
`else
        tick(14);
        expect_out("t2_e19", 3'b001, 2'd0, 1'b0, 1'b0);
        i_Ready = 3'b001;
        tick(2);
        expect_out("t2_e21", 3'b001, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("t2_e22", 3'b001, 2'd1, 1'b0, 1'b0);
        tick(2);
        expect_out("t2_e24", 3'b001, 2'd1, 1'b0, 1'b0);
        tick(1);
        expect_out("t2_e25", 3'b011, 2'd2, 1'b0, 1'b0);
        tick(1);
        expect_out("t2_e26", 3'b111, 2'd2, 1'b1, 1'b0);

        // No timeout build: ready never arrives, the wait must not give up.
        i_Enable = 1'b0;
        i_Ready  = 3'b000;
        tick(3);
        i_Enable = 1'b1;
        tick(1);
        tick(5);
        expect_out("wait_e5", 3'b001, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(100);
            expect_out($sformatf("wait_%0d", (i + 1) * 100), 3'b001, 2'd0, 1'b0, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
